native_axil_initiator: RTL and testbench

- Converts the core's native memory handshake (mem_valid/mem_ready) into single-beat AXI4-Lite read or write transactions on a mem_axi_* initiator port.
- It is the initiator end of the AXI4-Lite link whose responder is the bench memory model.
- Sits between a native-interface core and any AXI4-Lite responder. One transaction is outstanding at a time.
- A watchdog flags transactions that stall on the bus.

---
 rtl/native_axil_pkg.sv | 21 ++
 rtl/axil_watchdog.sv | 43 ++++
 rtl/native_axil_initiator.sv | 180 ++++++++++++++++++
 tb/tb_native_axil_initiator.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/native_axil_pkg.sv
// native_axil_pkg
//   Shared definitions for the native-to-AXI4-Lite initiator:
//   FSM state encoding, AXI protection codes and the default watchdog limit.
//   No ports (package).
package native_axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    localparam logic [2:0] PROT_DATA = 3'b000;
    localparam logic [2:0] PROT_INSN = 3'b100;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

endpackage

// File: rtl/axil_watchdog.sv
// axil_watchdog
//   Saturating stall counter with a sticky expiry flag.
//   Ports:
//     clk     in   system clock, rising edge
//     resetn  in   asynchronous active-low reset
//     enable  in   count this cycle
//     clear   in   return counter to zero (wins over enable)
//     expired out  sticky flag, set when the counter reaches LIMIT
//   LIMIT = 0 disables the watchdog entirely.
module axil_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW   = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CW-1:0] MAXC = CW'(LIMIT);
    localparam bit ENABLED = (LIMIT != 0);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count   <= '0;
            expired <= 1'b0;
        end else begin
            if (clear) begin
                count <= '0;
            end else if (enable && count != MAXC) begin
                count <= count + CW'(1);
            end
            // Flag rises on the same edge the counter lands on LIMIT.
            if (ENABLED && enable && !clear && count == MAXC - CW'(1)) begin
                expired <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/native_axil_initiator.sv
// native_axil_initiator
//   Bridges a native mem_valid/mem_ready request into a single-beat AXI4-Lite
//   read or write. One transaction outstanding at a time.
//   Ports:
//     clk, resetn            clock, asynchronous active-low reset
//     mem_valid/instr/addr/wdata/wstrb   native request (wstrb==0 -> read)
//     mem_ready, mem_rdata   one-cycle completion pulse and read data
//     mem_axi_aw*/w*/b*      AXI4-Lite write channels (initiator side)
//     mem_axi_ar*/r*         AXI4-Lite read channels (initiator side)
//     timeout_err            sticky watchdog flag for bus stalls
module native_axil_initiator
    import native_axil_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,

    output logic        mem_axi_awvalid,
    input  logic        mem_axi_awready,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,

    output logic        mem_axi_wvalid,
    input  logic        mem_axi_wready,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,

    input  logic        mem_axi_bvalid,
    output logic        mem_axi_bready,

    output logic        mem_axi_arvalid,
    input  logic        mem_axi_arready,
    output logic [31:0] mem_axi_araddr,
    output logic [2:0]  mem_axi_arprot,

    input  logic        mem_axi_rvalid,
    output logic        mem_axi_rready,
    input  logic [31:0] mem_axi_rdata,

    output logic        timeout_err
);

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        instr_q;
    logic        aw_done;
    logic        w_done;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign ar_hs = mem_axi_arvalid & mem_axi_arready;
    assign r_hs  = mem_axi_rvalid  & mem_axi_rready;
    assign aw_hs = mem_axi_awvalid & mem_axi_awready;
    assign w_hs  = mem_axi_wvalid  & mem_axi_wready;
    assign b_hs  = mem_axi_bvalid  & mem_axi_bready;

    // Payloads come straight from the request latch, so they are stable
    // for as long as any valid is held.
    assign mem_axi_awaddr = addr_q;
    assign mem_axi_araddr = addr_q;
    assign mem_axi_wdata  = wdata_q;
    assign mem_axi_wstrb  = wstrb_q;
    assign mem_axi_awprot = PROT_DATA;
    assign mem_axi_arprot = instr_q ? PROT_INSN : PROT_DATA;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            addr_q          <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            instr_q         <= 1'b0;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            mem_ready       <= 1'b0;
            mem_rdata       <= '0;
            mem_axi_awvalid <= 1'b0;
            mem_axi_wvalid  <= 1'b0;
            mem_axi_bready  <= 1'b0;
            mem_axi_arvalid <= 1'b0;
            mem_axi_rready  <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_valid) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        wstrb_q <= mem_wstrb;
                        instr_q <= mem_instr;
                        if (mem_wstrb == 4'b0000) begin
                            mem_axi_arvalid <= 1'b1;
                            state           <= RD_ADDR;
                        end else begin
                            mem_axi_awvalid <= 1'b1;
                            mem_axi_wvalid  <= 1'b1;
                            aw_done         <= 1'b0;
                            w_done          <= 1'b0;
                            state           <= WR_REQ;
                        end
                    end
                end
                RD_ADDR: begin
                    if (ar_hs) begin
                        mem_axi_arvalid <= 1'b0;
                        mem_axi_rready  <= 1'b1;
                        state           <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        mem_rdata      <= mem_axi_rdata;
                        mem_axi_rready <= 1'b0;
                        mem_ready      <= 1'b1;
                        state          <= DONE;
                    end
                end
                WR_REQ: begin
                    if (aw_hs) begin
                        mem_axi_awvalid <= 1'b0;
                        aw_done         <= 1'b1;
                    end
                    if (w_hs) begin
                        mem_axi_wvalid <= 1'b0;
                        w_done         <= 1'b1;
                    end
                    // Include this cycle's handshakes so a simultaneous or
                    // late-arriving pair advances without an extra cycle.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        mem_axi_bready <= 1'b1;
                        state          <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        mem_axi_bready <= 1'b0;
                        mem_ready      <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    // mem_ready is high during this state; IDLE does not
                    // sample mem_valid until the following edge.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic wd_enable;
    logic wd_clear;

    assign wd_enable = (state != IDLE) && (state != DONE);
    assign wd_clear  = (state == IDLE) | ar_hs | r_hs | aw_hs | w_hs | b_hs;

    axil_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .enable  (wd_enable),
        .clear   (wd_clear),
        .expired (timeout_err)
    );

endmodule

// File: tb/tb_native_axil_initiator.sv
// tb_native_axil_initiator
//   Directed bench for native_axil_initiator with a small AXI4-Lite responder
//   whose ready signals are driven directly by the stimulus sequence.
module tb_native_axil_initiator;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_axi_awvalid, mem_axi_awready;
    logic [31:0] mem_axi_awaddr;
    logic [2:0]  mem_axi_awprot;
    logic        mem_axi_wvalid, mem_axi_wready;
    logic [31:0] mem_axi_wdata;
    logic [3:0]  mem_axi_wstrb;
    logic        mem_axi_bvalid, mem_axi_bready;
    logic        mem_axi_arvalid, mem_axi_arready;
    logic [31:0] mem_axi_araddr;
    logic [2:0]  mem_axi_arprot;
    logic        mem_axi_rvalid, mem_axi_rready;
    logic [31:0] mem_axi_rdata;
    logic        timeout_err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    native_axil_initiator #(.TIMEOUT_CYCLES(16)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .mem_valid       (mem_valid),
        .mem_instr       (mem_instr),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata),
        .mem_axi_awvalid (mem_axi_awvalid),
        .mem_axi_awready (mem_axi_awready),
        .mem_axi_awaddr  (mem_axi_awaddr),
        .mem_axi_awprot  (mem_axi_awprot),
        .mem_axi_wvalid  (mem_axi_wvalid),
        .mem_axi_wready  (mem_axi_wready),
        .mem_axi_wdata   (mem_axi_wdata),
        .mem_axi_wstrb   (mem_axi_wstrb),
        .mem_axi_bvalid  (mem_axi_bvalid),
        .mem_axi_bready  (mem_axi_bready),
        .mem_axi_arvalid (mem_axi_arvalid),
        .mem_axi_arready (mem_axi_arready),
        .mem_axi_araddr  (mem_axi_araddr),
        .mem_axi_arprot  (mem_axi_arprot),
        .mem_axi_rvalid  (mem_axi_rvalid),
        .mem_axi_rready  (mem_axi_rready),
        .mem_axi_rdata   (mem_axi_rdata),
        .timeout_err     (timeout_err)
    );

    // ---------------- responder model ----------------
    logic [31:0] rd_value;
    logic        b_early;
    logic        aw_seen, w_seen;
    logic        s_ar, s_r, s_aw, s_w, s_b;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, r_cnt = 0;
    logic [31:0] last_araddr, last_awaddr, last_wdata;
    logic [3:0]  last_wstrb;
    logic [2:0]  last_arprot;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_axi_rvalid = 1'b0;
            mem_axi_bvalid = 1'b0;
            mem_axi_rdata  = '0;
            aw_seen        = 1'b0;
            w_seen         = 1'b0;
        end else begin
            // Sample handshakes with pre-edge values, then update after the edge.
            s_ar = mem_axi_arvalid && mem_axi_arready;
            s_r  = mem_axi_rvalid  && mem_axi_rready;
            s_aw = mem_axi_awvalid && mem_axi_awready;
            s_w  = mem_axi_wvalid  && mem_axi_wready;
            s_b  = mem_axi_bvalid  && mem_axi_bready;
            last_arprot = mem_axi_arprot;
            #1;
            if (s_r) begin
                r_cnt++;
                mem_axi_rvalid = 1'b0;
            end
            if (s_ar) begin
                ar_cnt++;
                last_araddr    = mem_axi_araddr;
                mem_axi_rvalid = 1'b1;
                mem_axi_rdata  = rd_value;
            end
            if (s_aw) begin
                aw_cnt++;
                aw_seen     = 1'b1;
                last_awaddr = mem_axi_awaddr;
            end
            if (s_w) begin
                w_cnt++;
                w_seen     = 1'b1;
                last_wdata = mem_axi_wdata;
                last_wstrb = mem_axi_wstrb;
            end
            if (s_b) begin
                b_cnt++;
                mem_axi_bvalid = 1'b0;
                aw_seen        = 1'b0;
                w_seen         = 1'b0;
                b_early        = 1'b0;
            end else if ((aw_seen && w_seen) || b_early) begin
                mem_axi_bvalid = 1'b1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic ins);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        mem_instr = ins;
    endtask

    // Request cycle counts as 1; returns at the negedge where mem_ready is seen.
    task automatic wait_ready(output int lat);
        lat = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            if (mem_ready) break;
        end
    endtask

    // Drop the request, then confirm the pulse was a single cycle.
    task automatic finish_txn(input string tag);
        mem_valid = 1'b0;
        @(negedge clk);
        check({tag, "_ready_one_cycle"}, mem_ready, 1'b0);
    endtask

    task automatic zero_wait_txn(input string tag, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] s);
        int lat;
        start(a, d, s, 1'b0);
        wait_ready(lat);
        check({tag, "_latency"}, lat, 4);
        finish_txn(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int ar0, aw0, b0;

        resetn          = 1'b0;
        mem_valid       = 1'b0;
        mem_instr       = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        mem_wstrb       = '0;
        mem_axi_arready = 1'b1;
        mem_axi_awready = 1'b1;
        mem_axi_wready  = 1'b1;
        rd_value        = '0;
        b_early         = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_valids", {mem_axi_awvalid, mem_axi_wvalid, mem_axi_arvalid,
                               mem_axi_rready, mem_axi_bready, mem_ready, timeout_err}, 7'b0);
        check("reset_rdata", mem_rdata, 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        // ---- 1: instruction-fetch read, zero-wait ----
        rd_value = 32'hCAFEF00D;
        start(32'h100, 32'h0, 4'b0000, 1'b1);
        @(negedge clk);
        check("rd_arvalid", mem_axi_arvalid, 1'b1);
        check("rd_araddr", mem_axi_araddr, 32'h100);
        check("rd_arprot", mem_axi_arprot, 3'b100);
        @(negedge clk);
        check("rd_arvalid_drop", mem_axi_arvalid, 1'b0);
        check("rd_rready", mem_axi_rready, 1'b1);
        @(negedge clk);
        check("rd_mem_ready", mem_ready, 1'b1);
        check("rd_rdata", mem_rdata, 32'hCAFEF00D);
        finish_txn("rd");

        // ---- 2: write, AW accepted 3 cycles before W ----
        mem_axi_wready = 1'b0;
        b0 = b_cnt;
        start(32'h2000_0000, 32'h075BCD15, 4'b1111, 1'b0);
        @(negedge clk);
        check("wr_aw_w_valid", {mem_axi_awvalid, mem_axi_wvalid}, 2'b11);
        check("wr_awprot", mem_axi_awprot, 3'b000);
        @(negedge clk);
        check("wr_aw_dropped", {mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready}, 3'b010);
        @(negedge clk);
        check("wr_w_held", {mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready}, 3'b010);
        @(negedge clk);
        mem_axi_wready = 1'b1;
        @(negedge clk);
        check("wr_bready_after_w", {mem_axi_wvalid, mem_axi_bready}, 2'b01);
        wait_ready(lat);
        check("wr_ready_seen", mem_ready, 1'b1);
        finish_txn("wr");
        check("wr_b_count", b_cnt - b0, 1);
        check("wr_awaddr", last_awaddr, 32'h2000_0000);
        check("wr_wdata", last_wdata, 32'h075BCD15);
        check("wr_wstrb", last_wstrb, 4'b1111);
        check("wr_rdata_kept", mem_rdata, 32'hCAFEF00D);

        // ---- 3: early bvalid must wait for AW and W ----
        mem_axi_awready = 1'b0;
        mem_axi_wready  = 1'b0;
        b0 = b_cnt;
        b_early = 1'b1;
        start(32'h44, 32'h5A5A5A5A, 4'b1000, 1'b0);
        @(negedge clk);
        check("eb_bvalid_early", mem_axi_bvalid, 1'b1);
        check("eb_bready_c1", mem_axi_bready, 1'b0);
        mem_axi_awready = 1'b1;
        @(negedge clk);
        check("eb_bready_c2", mem_axi_bready, 1'b0);
        @(negedge clk);
        check("eb_bready_after_aw", mem_axi_bready, 1'b0);
        mem_axi_wready = 1'b1;
        @(negedge clk);
        check("eb_bready_both", mem_axi_bready, 1'b1);
        wait_ready(lat);
        check("eb_ready_seen", mem_ready, 1'b1);
        finish_txn("eb");
        repeat (2) @(negedge clk);
        check("eb_one_b", b_cnt - b0, 1);

        // ---- 4: stalled AR trips the watchdog ----
        mem_axi_arready = 1'b0;
        rd_value = 32'h13579BDF;
        start(32'h40, 32'h0, 4'b0000, 1'b0);
        repeat (16) @(negedge clk);
        check("wd_not_yet", {timeout_err, mem_axi_arvalid}, 2'b01);
        @(negedge clk);
        check("wd_tripped", {timeout_err, mem_axi_arvalid}, 2'b11);
        check("wd_arprot_data", mem_axi_arprot, 3'b000);
        mem_axi_arready = 1'b1;
        wait_ready(lat);
        check("wd_ready_seen", mem_ready, 1'b1);
        check("wd_rdata", mem_rdata, 32'h13579BDF);
        finish_txn("wd");
        check("wd_sticky", timeout_err, 1'b1);

        // ---- 5: asynchronous reset in the middle of a write ----
        mem_axi_awready = 1'b0;
        mem_axi_wready  = 1'b0;
        aw0 = aw_cnt;
        start(32'h300, 32'h12345678, 4'b0001, 1'b0);
        @(negedge clk);
        check("rst_pre_valid", {mem_axi_awvalid, mem_axi_wvalid}, 2'b11);
        #2 resetn = 1'b0;
        #1;
        check("rst_async_outs", {mem_axi_awvalid, mem_axi_wvalid, mem_axi_arvalid,
                                 mem_axi_rready, mem_axi_bready, mem_ready, timeout_err}, 7'b0);
        check("rst_async_rdata", mem_rdata, 32'h0);
        mem_valid       = 1'b0;
        mem_axi_awready = 1'b1;
        mem_axi_wready  = 1'b1;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_no_resume", {mem_axi_awvalid, mem_axi_wvalid}, 2'b00);
        rd_value = 32'hA5A50000;
        zero_wait_txn("rst_rd0", 32'h0, 32'h0, 4'b0000);
        check("rst_rd0_rdata", mem_rdata, 32'hA5A50000);
        check("rst_rd0_addr", last_araddr, 32'h0);
        check("rst_no_aw", aw_cnt - aw0, 0);

        // ---- 6: back-to-back read / write / read ----
        ar0 = ar_cnt;
        aw0 = aw_cnt;
        rd_value = 32'h11111111;
        zero_wait_txn("b2b_rd1", 32'h4, 32'h0, 4'b0000);
        check("b2b_rd1_addr", last_araddr, 32'h4);
        check("b2b_rd1_data", mem_rdata, 32'h11111111);
        zero_wait_txn("b2b_wr", 32'h8, 32'hDEADBEEF, 4'b0011);
        check("b2b_wr_addr", last_awaddr, 32'h8);
        check("b2b_wr_strb", last_wstrb, 4'b0011);
        check("b2b_wr_rdata_kept", mem_rdata, 32'h11111111);
        rd_value = 32'h22222222;
        zero_wait_txn("b2b_rd2", 32'hC, 32'h0, 4'b0000);
        check("b2b_rd2_addr", last_araddr, 32'hC);
        check("b2b_rd2_data", mem_rdata, 32'h22222222);
        check("b2b_ar_count", ar_cnt - ar0, 2);
        check("b2b_aw_count", aw_cnt - aw0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
